dsp_i2s_transmitter: RTL and testbench
======================================

# dsp_i2s_transmitter

Serializes the DSP's stereo 16-bit output samples onto a standard I2S link (BCLK, LRCLK, SDATA) for an external audio codec. It is the consumer end of the DSP's once-per-sample DAC output. A one-entry holding register decouples the DSP's sample strobe from the serial frame. Sticky flags report overrun and underrun.

## Interface
- BCLK_HALF_PERIOD, default 1: clocks per BCLK half-period; must be ≥1. Frame length is 64·BCLK_HALF_PERIOD clocks; the default gives 64 clocks per frame, matching the DSP sample period.
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- sample_l  in  16  signed left sample.
- sample_r  in  16  signed right sample.
- sample_valid  in  1  one-cycle strobe; sample_l/sample_r are valid in that cycle.
- clear_flags  in  1  clears overrun and underrun.
- i2s_bclk  out  1  serial bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first, I2S one-bit delay.
- frame_start  out  1  one-cycle pulse on the first clock of each frame.
- overrun  out  1  sticky; a sample was overwritten before it was transmitted.
- underrun  out  1  sticky; a frame started with no new sample.

## Operation
**Counters**
- div_cnt runs 0..BCLK_HALF_PERIOD-1.
- phase runs 0..63 and advances when div_cnt is at terminal count.
- Bit index b = phase[5:1], range 0..31.

**Registered outputs**
- i2s_bclk = phase[0]: low on even phases, high on odd.
- i2s_lrclk = 1 when b ≥ 16.
- i2s_sdata changes only when entering an even phase (BCLK falling edge).

**Transmit word**
- W = {L, R}, 32 bits.
- In bit b = 1..31, sdata = W[32-b].
- In bit 0, sdata = W[0] of the previous frame's word (I2S delay).
- The left MSB therefore appears at b=1, and the right MSB at b=17.

**Holding register**
- On sample_valid: capture {sample_l, sample_r} into hold and set hold_full.
- If hold_full is already 1 and this is not the load cycle, the new data overwrites hold and overrun is set.

**Load (the edge with div_cnt terminal and phase=63)**
- The decision uses hold_full as it stood before this edge.
- If hold_full=1: W ← hold, and hold_full clears.
- If hold_full=0: W keeps its previous value (last word repeats) and underrun is set.
- sample_valid in the load cycle: hold is overwritten with the new sample and hold_full ends at 1. No overrun is flagged. The new sample is not loaded into this frame.
- frame_start pulses in the first cycle of phase 0.

**Flags**
- clear_flags clears overrun and underrun.
- If a set event occurs in the same cycle as clear_flags, set wins.

**Reset**
- Registers cleared: div_cnt, phase, W, hold, hold_full.
- Outputs forced to 0: overrun, underrun, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start.
- A reset mid-frame aborts the frame. Counting restarts at phase 0 on the first cycle after reset deasserts.
- The first frame after reset transmits zeros.

## Timing
- With BCLK_HALF_PERIOD=H:
  - i2s_bclk period is 2H clocks.
  - i2s_lrclk period is 64H clocks, with 50% duty.
  - Default: BCLK = clock/2, 32 BCLKs per frame.
- Outputs update on the clock edge after the counter state that defines them; there is no combinational path from inputs to outputs.
- Latency: a sample strobed during frame N is loaded at the N→N+1 boundary.
  - Left MSB is driven 2H clocks after frame_start of frame N+1.
  - Right LSB is driven in bit 0 of frame N+2.
- Producer contract: at most one sample_valid per frame. The DSP strobes once every 64 clocks, so with H=1 it must not drift relative to the frame (overrun/underrun otherwise).
- The first frame after reset ends at the first load edge, 64H-1 clocks after reset deasserts. Underrun sets there if no sample has arrived.

## Test plan
- **Reset and clocking:** hold reset 5 cycles with H=1, then release.
  - All outputs are 0 during reset.
  - i2s_bclk toggles every clock.
  - i2s_lrclk rises at clock 32 and falls at 64.
  - frame_start pulses every 64 clocks.
- **Serial bit order:** strobe L=16'h8001, R=16'h7FFE during frame 0.
  - Frame 1, b=1..16: sdata = 1000000000000001.
  - Frame 1, b=17..31: sdata = 011111111111111.
  - Frame 2, b=0: sdata = 0.
  - No flags set.
- **Underrun:** after the frame-1 word above, send no strobe.
  - underrun sets at the frame-2 load edge.
  - Frame 2 repeats the 8001/7FFE bit pattern.
- **Overrun:** strobe A=(16'h1111,16'h2222) and then B=(16'h3333,16'h4444) within one frame.
  - overrun sets on B's cycle.
  - The next frame carries B.
- **Simultaneous load and flag clear:** strobe in the exact load cycle.
  - No overrun.
  - The current frame repeats the old word and underrun sets.
  - The following frame carries the new sample.
  - Pulse clear_flags in a later underrun load cycle: underrun remains 1.
- **Reset mid-frame:** assert reset at phase 40 with hold_full=1 and both flags set.
  - Next cycle: all outputs and flags are 0 and hold_full=0.
  - The frame restarts at phase 0.
  - The first post-reset frame transmits all-zero data.

Source files
------------

// File: rtl/dsp_i2s_transmitter.sv
// dsp_i2s_transmitter
//   Serializes stereo 16-bit samples onto an I2S link (BCLK, LRCLK, SDATA).
//   A one-entry holding register decouples the DSP sample strobe from the
//   serial frame. Sticky overrun/underrun flags report producer slips.
//
// Parameters
//   BCLK_HALF_PERIOD  clocks per BCLK half-period (>=1); frame = 64*H clocks
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   sample_l/_r    signed 16-bit left/right sample, valid with sample_valid
//   sample_valid   one-cycle strobe
//   clear_flags    clears overrun/underrun (a coincident set event wins)
//   i2s_bclk       serial bit clock (phase[0])
//   i2s_lrclk      word select, 0 = left, 1 = right
//   i2s_sdata      serial data, MSB first, one-bit I2S delay
//   frame_start    one-cycle pulse on the first clock of each frame
//   overrun        sticky: held sample overwritten before transmission
//   underrun       sticky: frame started with no new sample
module dsp_i2s_transmitter #(
  parameter int unsigned BCLK_HALF_PERIOD = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  input  logic        clear_flags,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        overrun,
  output logic        underrun
);

  localparam int unsigned DW = (BCLK_HALF_PERIOD > 1) ? $clog2(BCLK_HALF_PERIOD) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [5:0]    phase_q, phase_d;
  logic [31:0]   word_q, word_d;
  logic          prev_lsb_q, prev_lsb_d;
  logic [31:0]   hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic          frame_start_q, frame_start_d;

  logic          tick;
  logic          load;
  logic          ovr_set;
  logic          und_set;
  logic [4:0]    bit_d;
  logic [4:0]    idx_d;

  assign tick = (div_q == DW'(BCLK_HALF_PERIOD - 1));
  assign load = tick && (phase_q == 6'd63);

  always_comb begin
    div_d       = tick ? '0 : div_q + DW'(1);
    phase_d     = tick ? phase_q + 6'd1 : phase_q;

    word_d      = word_q;
    prev_lsb_d  = prev_lsb_q;
    if (load) begin
      // Bit 0 of the next frame still belongs to the outgoing word.
      prev_lsb_d = word_q[0];
      if (hold_full_q) word_d = hold_q;
    end

    hold_d      = sample_valid ? {sample_l, sample_r} : hold_q;
    // In the load cycle the old contents leave for W, so a fresh strobe
    // simply refills the register rather than overrunning it.
    hold_full_d = load ? sample_valid : (hold_full_q | sample_valid);

    ovr_set     = sample_valid & hold_full_q & ~load;
    und_set     = load & ~hold_full_q;
    overrun_d   = (overrun_q  & ~clear_flags) | ovr_set;
    underrun_d  = (underrun_q & ~clear_flags) | und_set;

    // Outputs are registered from next-state counters so they line up
    // with the counter state that defines them.
    bit_d         = phase_d[5:1];
    idx_d         = 5'(6'd32 - {1'b0, bit_d});
    bclk_d        = phase_d[0];
    lrclk_d       = phase_d[5];
    frame_start_d = load;
    sdata_d       = sdata_q;
    if (tick && !phase_d[0]) begin
      sdata_d = (bit_d == 5'd0) ? prev_lsb_d : word_d[idx_d];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q         <= '0;
      phase_q       <= '0;
      word_q        <= '0;
      prev_lsb_q    <= 1'b0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      phase_q       <= phase_d;
      word_q        <= word_d;
      prev_lsb_q    <= prev_lsb_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign i2s_bclk    = bclk_q;
  assign i2s_lrclk   = lrclk_q;
  assign i2s_sdata   = sdata_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dsp_i2s_transmitter.sv
// tb_dsp_i2s_transmitter
//   Directed plus randomized stimulus for dsp_i2s_transmitter, checked every
//   cycle against a frame-level reference model derived from time since reset.
module tb_dsp_i2s_transmitter;

  localparam int unsigned H     = 1;
  localparam int unsigned FRAME = 64 * H;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, overrun, underrun;

  dsp_i2s_transmitter #(.BCLK_HALF_PERIOD(H)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model state: t = clocks since the first post-reset cycle.
  int unsigned t = 0;
  logic [31:0] hold_m = '0;
  logic [31:0] cur_m  = '0;
  logic        full_m = 1'b0;
  logic        prev_m = 1'b0;
  logic        ovr_m  = 1'b0;
  logic        und_m  = 1'b0;
  logic        sd_hist [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [15:0] l, input logic [15:0] r,
                      input logic clr, input logic rst);
    logic        load;
    logic        ovr_set;
    logic        und_set;
    int unsigned p;
    int unsigned b;
    logic        exp_sd;
    reset = rst; sample_valid = sv; sample_l = l; sample_r = r; clear_flags = clr;
    @(posedge clock);
    if (rst) begin
      t = 0; hold_m = '0; cur_m = '0; full_m = 1'b0; prev_m = 1'b0;
      ovr_m = 1'b0; und_m = 1'b0;
    end else begin
      load    = ((t % FRAME) == FRAME - 1);
      ovr_set = sv && full_m && !load;
      und_set = load && !full_m;
      if (load) begin
        prev_m = cur_m[0];
        if (full_m) cur_m = hold_m;
        full_m = sv;
      end else begin
        full_m = full_m | sv;
      end
      if (sv) hold_m = {l, r};
      ovr_m = (ovr_m && !clr) || ovr_set;
      und_m = (und_m && !clr) || und_set;
      t++;
    end
    #1;
    p = (t / H) % 64;
    b = p / 2;
    exp_sd = (b == 0) ? prev_m : cur_m[32 - b];
    check("bclk",        32'(i2s_bclk),    32'((p % 2) == 1));
    check("lrclk",       32'(i2s_lrclk),   32'(b >= 16));
    check("frame_start", 32'(frame_start), 32'(t != 0 && (t % FRAME) == 0));
    check("sdata",       32'(i2s_sdata),   32'(exp_sd));
    check("overrun",     32'(overrun),     32'(ovr_m));
    check("underrun",    32'(underrun),    32'(und_m));
    if (t < 1024) sd_hist[t] = i2s_sdata;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Advance until the current cycle sits at the given offset within the frame.
  task automatic run_to(input int unsigned off);
    for (int unsigned i = 0; i < FRAME && (t % FRAME) != off; i++)
      step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    step(1'b1, l, r, 1'b0, 1'b0);
  endtask

  // Reassemble the 32-bit word sent in frame f (bit 0 taken from frame f+1).
  function automatic logic [31:0] frame_word(input int unsigned f);
    logic [31:0] w;
    w = '0;
    for (int unsigned b = 1; b < 32; b++) w[32 - b] = sd_hist[f * FRAME + 2 * H * b];
    w[0] = sd_hist[(f + 1) * FRAME];
    return w;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] zero_acc;
    // Reset and clocking
    repeat (5) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Serial bit order, then underrun on the following frame
    run_to(10);
    strobe(16'h8001, 16'h7FFE);
    run_to(0);
    check("no_flags_f1", 32'({overrun, underrun}), 32'd0);
    run_to(63);
    idle(1);
    check("underrun_f2", 32'(underrun), 32'd1);
    idle(2 * FRAME - 1);
    check("bits_f1", frame_word(1), 32'h8001_7FFE);
    check("bits_f2", frame_word(2), 32'h8001_7FFE);

    // Overrun: B overwrites A inside one frame
    step(1'b0, '0, '0, 1'b1, 1'b0);
    run_to(5);
    strobe(16'h1111, 16'h2222);
    idle(3);
    strobe(16'h3333, 16'h4444);
    check("overrun_on_b", 32'(overrun), 32'd1);
    run_to(63);
    idle(1);

    // Strobe in the exact load cycle with an empty hold register
    step(1'b0, '0, '0, 1'b1, 1'b0);
    run_to(63);
    strobe(16'hA5C3, 16'h5A3C);
    check("load_strobe_ovr", 32'(overrun), 32'd0);
    check("load_strobe_und", 32'(underrun), 32'd1);
    run_to(63);
    idle(1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("und_cleared", 32'(underrun), 32'd0);
    run_to(63);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("set_wins_clear", 32'(underrun), 32'd1);

    // Randomized frames: 0, 1 or 2 strobes per frame, occasional clears
    for (int f = 0; f < 24; f++) begin
      int unsigned off1, off2;
      logic        none, dbl;
      off1 = $urandom_range(0, FRAME - 1);
      off2 = $urandom_range(0, FRAME - 1);
      none = ($urandom_range(0, 5) == 0);
      dbl  = ($urandom_range(0, 5) == 0);
      for (int unsigned c = 0; c < FRAME; c++) begin
        logic sv;
        sv = (!none && c == off1) || (dbl && c == off2);
        step(sv, 16'($urandom), 16'($urandom), ($urandom_range(0, 40) == 0), 1'b0);
      end
    end

    // Reset mid-frame with hold full and both flags set
    run_to(63);
    idle(1);
    run_to(63);
    idle(1);
    run_to(20);
    strobe(16'hDEAD, 16'hBEEF);
    strobe(16'hCAFE, 16'hF00D);
    check("pre_rst_flags", 32'({overrun, underrun}), 32'd3);
    run_to(40);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    check("rst_outputs", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, overrun, underrun}), 32'd0);
    idle(FRAME + 4);
    check("post_rst_underrun", 32'(underrun), 32'd1);
    zero_acc = '0;
    for (int unsigned i = 0; i <= FRAME; i++) zero_acc = zero_acc | 32'(sd_hist[i]);
    check("post_rst_zero_frame", zero_acc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
